// File: rtl/serial_compare_scheduler_if.sv
// Requester/result bundle for the shared serial comparator.
// Handshake: requester i transfers its (a, b) pair on a rising clock edge where
// req_valid[i] & req_ready[i] are both 1; once req_valid[i] is raised, the
// requester keeps it and its data stable until that edge. res_valid is a
// one-cycle strobe with no backpressure.
interface serial_compare_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   res_valid;
  logic [IDW-1:0]         res_id;
  logic                   res_less;
  logic                   res_eq;
  logic                   res_greater;
  logic                   busy;
  logic [1:0]             dbg_state;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_id, res_less, res_eq, res_greater,
           busy, dbg_state
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_id, res_less, res_eq, res_greater,
           busy, dbg_state
  );
endinterface

// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler in front of one bit-serial MSB-first magnitude
// comparator. A granted (a, b) pair is shifted through the comparator over
// WIDTH cycles, then a tagged less/eq/greater result is strobed for one cycle.
module serial_compare_scheduler #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  serial_compare_scheduler_if.slave  bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cmp_eq_q, cmp_eq_d;
  logic             cmp_less_q, cmp_less_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic             res_less_q, res_less_d;
  logic             res_eq_q, res_eq_d;
  logic             res_gt_q, res_gt_d;

  logic             any_valid;
  logic [IDW-1:0]   grant_id;
  logic [N_REQ-1:0] ready;
  logic             a_bit, b_bit, less_n, eq_n;

  // Round-robin pick: first valid requester scanning upward from ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    any_valid = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  // Next-state, datapath update and grant generation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    cnt_d      = cnt_q;
    cmp_eq_d   = cmp_eq_q;
    cmp_less_d = cmp_less_q;
    res_id_d   = res_id_q;
    res_less_d = res_less_q;
    res_eq_d   = res_eq_q;
    res_gt_d   = res_gt_q;
    ready      = '0;
    a_bit      = sh_a_q[WIDTH-1];
    b_bit      = sh_b_q[WIDTH-1];
    less_n     = cmp_less_q | (cmp_eq_q & ~a_bit & b_bit);
    eq_n       = cmp_eq_q & (a_bit == b_bit);
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          // No grant while reset is held, so no handshake can be lost.
          ready      = rst ? '0 : (N_REQ'(1) << grant_id);
          sh_a_d     = bus.req_a[grant_id*WIDTH +: WIDTH];
          sh_b_d     = bus.req_b[grant_id*WIDTH +: WIDTH];
          id_d       = grant_id;
          ptr_d      = (grant_id == IDW'(N_REQ-1)) ? '0 : grant_id + IDW'(1);
          cnt_d      = CW'(WIDTH-1);
          cmp_eq_d   = 1'b1;
          cmp_less_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        cmp_less_d = less_n;
        cmp_eq_d   = eq_n;
        sh_a_d     = {sh_a_q[WIDTH-2:0], 1'b0};
        sh_b_d     = {sh_b_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
          // Last bit: publish the final verdict so it is visible in DONE.
          res_id_d   = id_q;
          res_less_d = less_n;
          res_eq_d   = eq_n;
          res_gt_d   = ~less_n & ~eq_n;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      cnt_q      <= '0;
      cmp_eq_q   <= 1'b0;
      cmp_less_q <= 1'b0;
      res_id_q   <= '0;
      res_less_q <= 1'b0;
      res_eq_q   <= 1'b0;
      res_gt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      cnt_q      <= cnt_d;
      cmp_eq_q   <= cmp_eq_d;
      cmp_less_q <= cmp_less_d;
      res_id_q   <= res_id_d;
      res_less_q <= res_less_d;
      res_eq_q   <= res_eq_d;
      res_gt_q   <= res_gt_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.res_valid   = (state_q == DONE);
  assign bus.res_id      = res_id_q;
  assign bus.res_less    = res_less_q;
  assign bus.res_eq      = res_eq_q;
  assign bus.res_greater = res_gt_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Bench for serial_compare_scheduler: directed scenarios followed by random
// traffic, checked each cycle against a transaction-level reference model.
module tb_serial_compare_scheduler;
  localparam int WIDTH = 8;
  localparam int N_REQ = 4;
  localparam int IDW   = 2;
  localparam int RW    = IDW + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_compare_scheduler_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  serial_compare_scheduler #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- requester state ----------------
  logic [WIDTH-1:0] a_v [N_REQ];
  logic [WIDTH-1:0] b_v [N_REQ];
  logic [N_REQ-1:0] v;
  logic [N_REQ-1:0] hs;
  int               refill [N_REQ];
  bit               rand_on;

  // ---------------- reference model / scoreboard ----------------
  int            ptr_m;
  int            cnt_m;       // cycles of busy left; 1 means result cycle
  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] last_res;
  int            gnt_id_log [$];
  int            gnt_cyc_log [$];
  int            cyc;
  int            errors;
  int            checks;

  function automatic logic [RW-1:0] ref_cmp(int id, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    int ai, bi;
    logic [IDW-1:0] idl;
    ai  = int'(a);
    bi  = int'(b);
    idl = id[IDW-1:0];
    return {idl, ai < bi, ai == bi, ai > bi};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply();
    bus.req_valid = v;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = a_v[i];
      bus.req_b[i*WIDTH +: WIDTH] = b_v[i];
    end
  endtask

  task automatic offer(int i, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    a_v[i] = a;
    b_v[i] = b;
    v[i]   = 1'b1;
    apply();
  endtask

  task automatic rand_pair(int i);
    logic [WIDTH-1:0] a, b;
    a = WIDTH'($urandom);
    case ($urandom_range(0, 3))
      0: b = WIDTH'($urandom);
      1: b = a;
      2: b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH-1));
      default: begin
        a = $urandom_range(0, 1) ? '1 : '0;
        b = $urandom_range(0, 1) ? '1 : '0;
      end
    endcase
    a_v[i] = a;
    b_v[i] = b;
  endtask

  // One clock: check at negedge against the model, then update requesters after posedge.
  task automatic tick();
    logic [N_REQ-1:0] exp_ready;
    int g, idx;
    @(negedge clk);
    cyc++;
    exp_ready = '0;
    g = -1;
    if (cnt_m == 0) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (ptr_m + k) % N_REQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check("busy", 64'(bus.busy), 64'(cnt_m != 0));
    check("res_valid", 64'(bus.res_valid), 64'(cnt_m == 1));
    if (cnt_m == 1 && exp_q.size() > 0) last_res = exp_q.pop_front();
    check("result", 64'({bus.res_id, bus.res_less, bus.res_eq, bus.res_greater}), 64'(last_res));
    if (g >= 0) begin
      exp_q.push_back(ref_cmp(g, a_v[g], b_v[g]));
      ptr_m = (g + 1) % N_REQ;
      cnt_m = WIDTH + 1;
      hs[g] = 1'b1;
      gnt_id_log.push_back(g);
      gnt_cyc_log.push_back(cyc);
    end else if (cnt_m > 0) begin
      cnt_m--;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (hs[i]) begin
        if (refill[i] > 0) begin
          refill[i]--;
          rand_pair(i);
        end else begin
          v[i] = 1'b0;
        end
      end
    end
    hs = '0;
    if (rand_on) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!v[i] && $urandom_range(0, 3) == 0) begin
          rand_pair(i);
          v[i] = 1'b1;
        end
      end
    end
    apply();
  endtask

  task automatic run_until_idle(int max_cycles);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((cnt_m != 0 || v != '0) && n < max_cycles);
    check("idle_timeout", 64'(cnt_m != 0 || v != '0), 64'(0));
  endtask

  task automatic do_reset(int hold);
    rst = 1'b1;
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_res_valid", 64'(bus.res_valid), 64'(0));
    check("rst_result", 64'({bus.res_id, bus.res_less, bus.res_eq, bus.res_greater}), 64'(0));
    ptr_m    = 0;
    cnt_m    = 0;
    last_res = '0;
    hs       = '0;
    exp_q.delete();
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int base;
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    v       = '0;
    hs      = '0;
    rand_on = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      a_v[i]    = '0;
      b_v[i]    = '0;
      refill[i] = 0;
    end
    apply();
    do_reset(2);
    repeat (3) tick();

    // Equal operands, then the three ordering cases on requester 0.
    base = gnt_cyc_log.size();
    offer(0, 8'h5A, 8'h5A);
    run_until_idle(40);
    check("t1_grant_count", 64'(gnt_cyc_log.size() - base), 64'(1));
    check("t1_result", 64'({bus.res_id, bus.res_less, bus.res_eq, bus.res_greater}), 64'(5'b00_010));
    offer(0, 8'h80, 8'h7F); run_until_idle(40);
    check("t2_gt", 64'(bus.res_greater), 64'(1));
    offer(0, 8'h01, 8'h02); run_until_idle(40);
    check("t2_lt", 64'(bus.res_less), 64'(1));
    offer(0, 8'hFF, 8'h00); run_until_idle(40);
    check("t2_gt_ext", 64'(bus.res_greater), 64'(1));

    // All four pending: round-robin order 0,1,2,3,0 spaced WIDTH+2 apart.
    do_reset(2);
    base = gnt_id_log.size();
    refill[0] = 1;
    offer(0, 8'h10, 8'h20);
    offer(1, 8'h33, 8'h33);
    offer(2, 8'hC0, 8'h0C);
    offer(3, 8'h00, 8'hFF);
    run_until_idle(120);
    check("t3_grant_count", 64'(gnt_id_log.size() - base), 64'(5));
    for (int k = 0; k < 5; k++) begin
      check("t3_order", 64'(gnt_id_log[base+k]), 64'(k % N_REQ));
      if (k > 0)
        check("t3_spacing", 64'(gnt_cyc_log[base+k] - gnt_cyc_log[base+k-1]), 64'(WIDTH + 2));
    end

    // After a grant to 2, requesters 1 and 3 pending: 3 wins first.
    offer(2, 8'h44, 8'h45); run_until_idle(40);
    base = gnt_id_log.size();
    offer(1, 8'h12, 8'h12);
    offer(3, 8'h99, 8'h98);
    run_until_idle(60);
    check("t4_first", 64'(gnt_id_log[base]), 64'(3));
    check("t4_second", 64'(gnt_id_log[base+1]), 64'(1));

    // Reset during the shift: transaction dropped, pointer back to 0.
    offer(3, 8'h01, 8'h00);
    tick();                       // grant to 3
    repeat (4) tick();            // four bits shifted
    do_reset(2);
    base = gnt_id_log.size();
    offer(0, 8'h21, 8'h12);
    offer(1, 8'h00, 8'h00);
    offer(2, 8'h7F, 8'h80);
    offer(3, 8'hAA, 8'hAB);
    run_until_idle(120);
    check("t5_first_after_rst", 64'(gnt_id_log[base]), 64'(0));

    // Request raised while busy waits for IDLE, then is granted at once.
    base = gnt_id_log.size();
    offer(0, 8'h3C, 8'h3D);
    repeat (3) tick();
    offer(1, 8'hE7, 8'h7E);
    run_until_idle(60);
    check("t6_id", 64'(gnt_id_log[base+1]), 64'(1));
    check("t6_gap", 64'(gnt_cyc_log[base+1] - gnt_cyc_log[base]), 64'(WIDTH + 2));

    // Random traffic.
    rand_on = 1'b1;
    repeat (600) tick();
    rand_on = 1'b0;
    run_until_idle(200);
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
